// File: rtl/bnn_pkg.sv
// rtl/bnn_pkg.sv - shared types and sizing helpers for the BNN parameter loader
// Purpose: loader state encoding, byte geometry and chain-length helpers.
// Contents: state_e (IDLE/WAIT_BYTE/SHIFT/DONE), BYTE_W, IDX_W,
//           chain_bits(neurons, inputs, bias_bits), nbytes(neurons, inputs, bias_bits).
package bnn_pkg;

  localparam int BYTE_W = 8;
  localparam int IDX_W  = 3;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_BYTE = 2'd1,
    ST_SHIFT     = 2'd2,
    ST_DONE      = 2'd3
  } state_e;

  // Total parameter bits held by the neuron daisy-chain.
  function automatic int chain_bits(input int neurons, input int inputs, input int bias_bits);
    return neurons * (inputs + bias_bits);
  endfunction

  // Host bytes needed to cover the chain; the last one may be partially used.
  function automatic int nbytes(input int neurons, input int inputs, input int bias_bits);
    return (chain_bits(neurons, inputs, bias_bits) + BYTE_W - 1) / BYTE_W;
  endfunction

endpackage

// File: rtl/bnn_byte_serializer.sv
// rtl/bnn_byte_serializer.sv - byte shift register with bit index, MSB-first
// Purpose: parallel-load / serial-shift byte register used both to serialise host
//          bytes onto the chain and (with sin) to gather bits leaving the chain.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clear        zero sreg and bit_idx (start of a new load)
//   load         sreg <= din, bit_idx <= 0 (wins over shift)
//   shift        sreg <= {sreg[6:0], sin}, bit_idx++
//   din[7:0]     parallel byte
//   sin          serial bit entering at the LSB
//   sreg[7:0]    register contents; sreg[7] is the next bit out
//   bit_idx[2:0] bits shifted since the last load/clear (mod 8)
module bnn_byte_serializer import bnn_pkg::*; (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              load,
  input  logic              shift,
  input  logic [BYTE_W-1:0] din,
  input  logic              sin,
  output logic [BYTE_W-1:0] sreg,
  output logic [IDX_W-1:0]  bit_idx
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg    <= '0;
      bit_idx <= '0;
    end else if (clear) begin
      sreg    <= '0;
      bit_idx <= '0;
    end else if (load) begin
      sreg    <= din;
      bit_idx <= '0;
    end else if (shift) begin
      sreg    <= {sreg[BYTE_W-2:0], sin};
      bit_idx <= bit_idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/bnn_param_loader.sv
// rtl/bnn_param_loader.sv - serial weight/bias loader for the neuron daisy-chain
// Purpose: takes host bytes on a valid/ready port and shifts them MSB-first into the
//          chain head with setup high for exactly CHAIN_BITS cycles, then reports done.
// Optional feature: BNN_LOADER_READBACK_EN returns the bits leaving the chain tail as
//          bytes on rb_data/rb_valid; without it rb_data/rb_valid are tied to zero.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               begin a load (honoured in IDLE or DONE only)
//   in_data/in_valid    host byte and its valid; in_ready accepts it
//   setup, param_out    chain shift enable and serial bit to the chain head
//   chain_tail          bit leaving the last neuron (readback only)
//   busy, done          load in progress / load complete
//   rb_data, rb_valid   readback byte and strobe
module bnn_param_loader import bnn_pkg::*; #(
  parameter int NEURONS   = 8,
  parameter int INPUTS    = 8,
  parameter int BIAS_BITS = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       setup,
  output logic       param_out,
  input  logic       chain_tail,
  output logic       busy,
  output logic       done,
  output logic [7:0] rb_data,
  output logic       rb_valid
);

  localparam int CHAIN_BITS = chain_bits(NEURONS, INPUTS, BIAS_BITS);
  localparam int CNT_W      = $clog2(CHAIN_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_BITS - 1);

  state_e            state, state_nxt;
  logic [CNT_W-1:0]  bit_cnt;
  logic [BYTE_W-1:0] ser_q;
  logic [IDX_W-1:0]  ser_idx;
  logic              shifting, last_bit, byte_end, start_ok, xfer;
  logic              unused_ser;

  assign shifting = (state == ST_SHIFT);
  assign last_bit = shifting && (bit_cnt == LAST_BIT);
  assign byte_end = shifting && (ser_idx == IDX_W'(BYTE_W - 1));
  assign start_ok = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign xfer     = in_valid && in_ready;

  // Only the bit after the current MSB is needed to pre-compute param_out.
  assign unused_ser = ^{ser_q[7], ser_q[5:0]};

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) state_nxt = ST_WAIT_BYTE;
      end
      ST_WAIT_BYTE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (last_bit) begin
          state_nxt = ST_DONE;
        end else if (byte_end) begin
          // Accepting the next byte on the 8th bit keeps setup continuous.
          in_ready  = 1'b1;
          state_nxt = in_valid ? ST_SHIFT : ST_WAIT_BYTE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      setup     <= 1'b0;
      param_out <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state <= state_nxt;
      setup <= (state_nxt == ST_SHIFT);
      busy  <= (state_nxt == ST_WAIT_BYTE) || (state_nxt == ST_SHIFT);
      done  <= (state_nxt == ST_DONE);
      // param_out is the MSB the serializer will hold next cycle.
      if (state_nxt == ST_SHIFT) param_out <= xfer ? in_data[7] : ser_q[6];
      else                       param_out <= 1'b0;
      if (start_ok)      bit_cnt <= '0;
      else if (shifting) bit_cnt <= bit_cnt + CNT_W'(1);
    end
  end

  bnn_byte_serializer u_ser (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (start_ok),
    .load    (xfer),
    .shift   (shifting),
    .din     (in_data),
    .sin     (1'b0),
    .sreg    (ser_q),
    .bit_idx (ser_idx)
  );

`ifdef BNN_LOADER_READBACK_EN
  logic [BYTE_W-1:0] rb_q;
  logic [IDX_W-1:0]  rb_idx;
  logic              unused_rb;

  assign unused_rb = rb_q[7];

  // Every setup cycle the old bit at the chain tail is captured MSB-first.
  bnn_byte_serializer u_deser (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (start_ok),
    .load    (1'b0),
    .shift   (shifting),
    .din     ('0),
    .sin     (chain_tail),
    .sreg    (rb_q),
    .bit_idx (rb_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rb_data  <= '0;
      rb_valid <= 1'b0;
    end else begin
      rb_valid <= 1'b0;
      if (shifting && ((rb_idx == IDX_W'(BYTE_W - 1)) || last_bit)) begin
        rb_valid <= 1'b1;
        // A short final byte is left-aligned with zero padding.
        rb_data  <= {rb_q[BYTE_W-2:0], chain_tail} << (IDX_W'(BYTE_W - 1) - rb_idx);
      end
    end
  end
`else
  logic unused_tail;

  assign unused_tail = chain_tail;
  assign rb_data     = '0;
  assign rb_valid    = 1'b0;
`endif

endmodule

// File: tb/tb_bnn_param_loader.sv
// tb/tb_bnn_param_loader.sv - self-checking bench for bnn_param_loader
module tb_bnn_param_loader;
  import bnn_pkg::*;

  localparam int CB0 = chain_bits(8, 8, 3);
  localparam int NB0 = nbytes(8, 8, 3);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic in_ready, setup, param_out, chain_tail, busy, done, rb_valid;
  logic [7:0] rb_data;
  logic start_1 = 1'b0, in_valid_1 = 1'b0;
  logic [7:0] in_data_1 = '0;
  logic in_ready_1, setup_1, param_out_1, chain_tail_1, busy_1, done_1, rb_valid_1;
  logic [7:0] rb_data_1;

  logic [CB0-1:0] chain0 = '0;
  logic [10:0]    chain1 = '0;

  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  bnn_param_loader u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .setup(setup), .param_out(param_out), .chain_tail(chain_tail),
    .busy(busy), .done(done), .rb_data(rb_data), .rb_valid(rb_valid)
  );

  bnn_param_loader #(.NEURONS(1), .INPUTS(8), .BIAS_BITS(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_1), .in_data(in_data_1), .in_valid(in_valid_1),
    .in_ready(in_ready_1), .setup(setup_1), .param_out(param_out_1), .chain_tail(chain_tail_1),
    .busy(busy_1), .done(done_1), .rb_data(rb_data_1), .rb_valid(rb_valid_1)
  );

  // Neuron chains: first bit in ends at index 0 after a full load; index 0 is the tail.
  always @(posedge clk) begin
    if (setup)   chain0 <= {param_out, chain0[CB0-1:1]};
    if (setup_1) chain1 <= {param_out_1, chain1[10:1]};
  end
  assign chain_tail   = chain0[0];
  assign chain_tail_1 = chain1[0];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: accepted bytes become a bit queue; each setup cycle must carry the next bit.
  bit exp_q[$];
  logic [7:0] rb_got[$];
  int shifted = 0, setup_cnt = 0, stall_cnt = 0;
  bit loading = 0, exp_done = 0, exp_busy = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_outputs", {setup, param_out, in_ready, busy, done, rb_valid, rb_data}, 0);
      loading = 0; exp_done = 0; exp_busy = 0; shifted = 0; exp_q.delete();
    end else begin
      if (setup) begin
        if (exp_q.size() == 0 || shifted >= CB0) begin
          checks++; errors++;
          $display("FAIL setup_overrun: setup high with %0d bits shifted, required at most %0d", shifted, CB0);
        end else begin
          chk("param_out", param_out, exp_q.pop_front());
        end
        shifted++; setup_cnt++;
      end else if (loading && shifted > 0 && shifted < CB0) begin
        stall_cnt++;
      end
      chk("done", done, exp_done);
      chk("busy", busy, exp_busy);
      if (!exp_busy) chk("in_ready_idle", in_ready, 0);
`ifdef BNN_LOADER_READBACK_EN
      if (rb_valid) rb_got.push_back(rb_data);
`else
      chk("rb_idle", {rb_valid, rb_data}, 0);
`endif
      if (in_valid && in_ready)
        for (int j = 7; j >= 0; j--) exp_q.push_back(in_data[j]);
      if (start && !loading) begin
        loading = 1; exp_busy = 1; exp_done = 0;
        shifted = 0; setup_cnt = 0; stall_cnt = 0; exp_q.delete();
      end else if (setup && shifted == CB0) begin
        loading = 0; exp_busy = 0; exp_done = 1; exp_q.delete();
      end
    end
  end

  function automatic logic [CB0-1:0] pack(input logic [7:0] b [NB0]);
    logic [CB0-1:0] v;
    for (int o = 0; o < CB0; o++) v[o] = b[o / 8][7 - (o % 8)];
    return v;
  endfunction

  function automatic logic [7:0] axons(input logic [CB0-1:0] c);
    logic [7:0] a, w;
    logic [2:0] bb;
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < 8; i++) w[7 - i] = c[n * 11 + i];
      for (int i = 0; i < 3; i++) bb[2 - i] = c[n * 11 + 8 + i];
      a[n] = ($countones(w) > int'(bb));
    end
    return a;
  endfunction

  // Host driver; inputs change 2 time units after the rising edge.
  task automatic run_load(input logic [7:0] b [NB0], input int gap_idx, input int gap_len,
                          input int restart_bit, input int rst_bit);
    int k, hold, cyc;
    bit took, fired;
    k = 0; hold = 0; cyc = 0; fired = 0;
    start = 1; @(posedge clk); #2; start = 0;
    while (!done) begin
      if (cyc >= 3000) begin
        checks++; errors++;
        $display("FAIL load_timeout: done=%0b after %0d cycles, required 1", done, cyc);
        break;
      end
      start = 0;
      if (!fired && restart_bit >= 0 && setup_cnt == restart_bit) begin start = 1; fired = 1; end
      if (!fired && rst_bit >= 0 && setup_cnt == rst_bit) begin
        rst_n = 0; in_valid = 0; fired = 1; #1;
        chk("async_reset", {setup, param_out, in_ready, busy, done, rb_valid, rb_data}, 0);
        break;
      end
      in_valid = (hold == 0 && k < NB0);
      if (k < NB0) in_data = b[k];
      // The gap counts only cycles where the loader is waiting with setup low.
      if (hold > 0 && in_ready && !setup) hold--;
      took = in_valid && in_ready;
      @(posedge clk); #2; cyc++;
      if (took) begin
        if (k == gap_idx) hold = gap_len;
        k++;
      end
    end
    start = 0; in_valid = 0;
  endtask

  task automatic run_u1(input logic [7:0] b0, input logic [7:0] b1, output logic [10:0] bits,
                        output int ns, output int acc, output logic [15:0] rb, output int nrb);
    logic [7:0] q [3];
    int k;
    bit took;
    q[0] = b0; q[1] = b1; q[2] = 8'hFF;
    k = 0; bits = '0; ns = 0; acc = 0; rb = '0; nrb = 0;
    start_1 = 1; @(posedge clk); #2; start_1 = 0;
    repeat (40) begin
      in_valid_1 = (k < 3);
      if (k < 3) in_data_1 = q[k];
      @(negedge clk);
      if (setup_1) begin bits = {bits[9:0], param_out_1}; ns++; end
      if (rb_valid_1) begin rb = {rb[7:0], rb_data_1}; nrb++; end
      took = in_valid_1 && in_ready_1;
      @(posedge clk); #2;
      if (took) begin k++; acc++; end
    end
    in_valid_1 = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [7:0] p1 [NB0], p3 [NB0], p5a [NB0], p5b [NB0], p6 [NB0], wb [NB0];
    logic [7:0] w [8];
    logic [2:0] bz [8];
    logic [CB0-1:0] v;
    logic [10:0] bits1;
    logic [15:0] rb1;
    int ns1, acc1, nrb1;

    p1  = '{8'hC5, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h0F, 8'h81};
    p3  = '{8'h01, 8'h80, 8'hFF, 8'h00, 8'h55, 8'hAA, 8'h3C, 8'hC3, 8'h69, 8'h96, 8'h7E};
    p5a = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    p5b = '{8'h11, 8'h22, 8'h44, 8'h88, 8'hE1, 8'hD2, 8'hB4, 8'h78, 8'h0A, 8'hA0, 8'h5F};
    p6  = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A};
    w   = '{8'hFF, 8'h00, 8'h0F, 8'h01, 8'h3F, 8'h07, 8'hF0, 8'h80};
    bz  = '{3'd7, 3'd0, 3'd3, 3'd1, 3'd5, 3'd3, 3'd4, 3'd0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_state", {setup, param_out, in_ready, busy, done, rb_valid, rb_data}, 0);
    @(posedge clk); #2; rst_n = 1;
    repeat (2) @(posedge clk); #2;

    // 1: back-to-back bytes, 88 contiguous setup cycles
    run_load(p1, -1, 0, -1, -1);
    chk("t1_setup_cycles", setup_cnt, 88);
    chk("t1_stalls", stall_cnt, 0);
    chk("t1_chain", chain0, pack(p1));
    chk("t1_first_byte_order", chain0[7:0], 8'hA3);
    chk("t1_done", done, 1);
    repeat (2) @(posedge clk); #2;

    // 2: known weights/bias -> axon = popcount(w) > bias with all inputs high
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < 8; i++) v[n * 11 + i] = w[n][7 - i];
      for (int i = 0; i < 3; i++) v[n * 11 + 8 + i] = bz[n][2 - i];
    end
    for (int o = 0; o < CB0; o++) wb[o / 8][7 - (o % 8)] = v[o];
    run_load(wb, -1, 0, -1, -1);
    chk("t2_chain", chain0, v);
    chk("t2_axons", axons(chain0), 8'h95);

    // 3: three idle host cycles after the 4th byte
    run_load(p3, 3, 3, -1, -1);
    chk("t3_setup_cycles", setup_cnt, 88);
    chk("t3_stalls", stall_cnt, 4);
    chk("t3_chain", chain0, pack(p3));

    // 4: 11-bit chain, partial final byte
    run_u1(8'hA5, 8'hE0, bits1, ns1, acc1, rb1, nrb1);
    chk("t4_setup_cycles", ns1, 11);
    chk("t4_bits", bits1, 11'b101_0010_1111);
    chk("t4_bytes_taken", acc1, 2);
    chk("t4_done", done_1, 1);
    chk("t4_chain", chain1, 11'b111_1010_0101);

    // 5: reset at bit 40, then a clean reload with an ignored mid-load start
    run_load(p5a, -1, 0, -1, 40);
    @(posedge clk); #2; rst_n = 1;
    repeat (2) @(posedge clk); #2;
    chk("t5_idle_after_reset", {busy, done, setup}, 0);
    run_load(p5b, -1, 0, 20, -1);
    chk("t5_setup_cycles", setup_cnt, 88);
    chk("t5_chain", chain0, pack(p5b));
    chk("t5_done", done, 1);

`ifdef BNN_LOADER_READBACK_EN
    // 6: the next load returns the previous pattern, padded tail included
    rb_got.delete();
    run_load(p6, -1, 0, -1, -1);
    repeat (2) @(posedge clk); #2;
    chk("t6_rb_count", rb_got.size(), NB0);
    for (int k = 0; k < NB0 && k < rb_got.size(); k++) chk("t6_rb_byte", rb_got[k], p5b[k]);
    chk("t6_rb_first", rb_got.size() > 0 ? rb_got[0] : 8'h00, 8'h11);
    run_u1(8'h5A, 8'hFF, bits1, ns1, acc1, rb1, nrb1);
    chk("t6_u1_rb_count", nrb1, 2);
    chk("t6_u1_rb", rb1, 16'hA5E0);
`else
    run_u1(8'h5A, 8'hFF, bits1, ns1, acc1, rb1, nrb1);
    chk("t6_u1_no_rb", nrb1, 0);
    chk("t6_u1_bits", bits1, 11'b010_1101_0111);
`endif

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
